alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command-side companion to the 8-bit registered ALU. It accepts operand/opcode commands over a valid/ready interface, drives the ALU's `a`/`b`/`op` inputs from registers, and tracks each command through the ALU's fixed pipeline. It captures `result`/`zero` at the correct cycle and returns them in order over a valid/ready response interface, with a bounded response FIFO providing backpressure.

## Interface
- `PIPE_LAT`, 3: clock edges from issue (alu_* outputs update) to the capture of `alu_result`. This is fixed by the ALU (input reg, output reg, 1 sample edge).
- `RSP_DEPTH`, 8: response FIFO entries. Must be a power of 2 and ≥ 2.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset. It is shared with the ALU.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on `cmd_valid & cmd_ready` at a rising edge.
- `cmd_a` in 8: operand A.
- `cmd_b` in 8: operand B.
- `cmd_op` in 2: 00 ADD, 01 AND, 10 OR, 11 XOR.
- `alu_a` out 8: registered, to ALU `a`.
- `alu_b` out 8: registered, to ALU `b`.
- `alu_op` out 2: registered, to ALU `op`.
- `alu_result` in 8: from ALU `result`.
- `alu_zero` in 1: from ALU `zero`.
- `rsp_valid` out 1: FIFO head valid.
- `rsp_ready` in 1: consumer accepts the head.
- `rsp_result` out 8: head result.
- `rsp_zero` out 1: head zero flag.
- `rsp_err` out 1: head checker mismatch. This is 0 when the checker is compiled out.
- `busy` out 1: any command in flight or any FIFO entry is occupied.

## Operation
- **Credit count**: credit = in-flight count + FIFO count.
  - `cmd_ready` = credit < RSP_DEPTH.
  - It is derived from registered state only, with no path from `rsp_ready` or `cmd_valid`.
- **Accept**: load `alu_a`/`alu_b`/`alu_op` from `cmd_*`, and set bit 0 of a PIPE_LAT-long valid shift register.
  - With no accept, `alu_*` hold their last value. The ALU still computes on them, but the issuer does not capture the result.
- **Capture**: when a valid bit exits the shift register, push {`alu_result`, `alu_zero`, err} into the FIFO at that edge.
- **FIFO**: first-word-fall-through. `rsp_valid` = not empty. A pop occurs on `rsp_valid & rsp_ready`.
  - Push and pop in the same cycle are legal, including when the FIFO is full or empty.
  - Overflow is impossible by construction. The bench asserts this.
- **Ordering**: responses are returned strictly in acceptance order. There is no tag.
- **Throughput**: one command per cycle is sustained with `rsp_ready` high, provided RSP_DEPTH ≥ PIPE_LAT+2.
- **Reset** (asynchronous, any time):
  - The shift register, FIFO pointers and `alu_*` clear to 0.
  - Afterwards `rsp_valid`=0, `rsp_*`=0, `busy`=0, `cmd_ready`=1.
  - Commands in flight when reset asserts are discarded silently. The ALU is reset by the same `rst_n`.
  - Commands presented while `rst_n` is low are ignored.

## Timing
- Accept at edge E0 → ALU samples at E1 → ALU output register at E2 → push at E3 → `rsp_valid` high in the cycle after E3.
- Latency from accept to `rsp_valid` is 3 cycles, assuming an empty FIFO ahead of it.
- `cmd_ready` falls in the cycle after the credit reaches RSP_DEPTH. It rises in the cycle after the pop that frees a credit.
- All outputs are registered except `rsp_*` (FIFO read mux) and `cmd_ready` (compare of registered counts).

## Configuration
- Macro: `ALU_ISSUER_CHECK_EN`.
- **Defined**: a copy of {a, b, op} travels alongside each valid bit. At capture, the issuer computes the expected value:
  - ADD: 8-bit sum, modulo 256, carry dropped.
  - AND, OR, XOR: the bitwise operation.
  - expected zero = (expected == 0).
  - `rsp_err` = 1 if the result or the zero flag differs from expected.
- **Undefined**: no operand copies, no compare logic. `rsp_err` is tied to 0 and the FIFO err bit is not stored.

## Structure
- Package `alu_issuer_pkg`:
  - `DATA_W`=8, `OP_W`=2, `PIPE_LAT`=3.
  - Opcode constants `OP_ADD`/`OP_AND`/`OP_OR`/`OP_XOR`.
  - The response struct {result, zero, err}.
  - Reference function `alu_ref(a, b, op)`, used by both the checker and the bench.
- Sub-module `alu_rsp_fifo`: synchronous FWFT FIFO.
  - Parameterized by depth and width.
  - Outputs a count.
  - Asynchronous active-low reset.

## Test plan
- **Reset**: hold `rst_n` low 3 cycles, then release.
  - Required: `alu_a`/`alu_b`/`alu_op`=0, `rsp_valid`=0, `busy`=0, `cmd_ready`=1.
- **Single ADD**: `cmd_a`=0xF0, `cmd_b`=0x20, op=00 accepted at E0.
  - Required: `rsp_valid` high after E3 with `rsp_result`=0x10, `rsp_zero`=0, `rsp_err`=0.
- **Back-to-back**: four commands on consecutive cycles: 0x01+0xFF, 0x0F&0xF0, 0xA0|0x05, 0x5A^0x5A.
  - Required: responses on 4 consecutive cycles: (0x00, z=1), (0x00, z=1), (0xA5, z=0), (0x00, z=1).
- **Backpressure**: hold `rsp_ready`=0 and stream 12 commands.
  - Required: exactly 8 are accepted and `cmd_ready` stays 0.
  - Raise `rsp_ready`: all 8 responses come out in order, with no loss or duplication. Then the remaining 4 are accepted.
- **Reset mid-flight**: 3 commands in flight, pulse `rst_n` low for 1 cycle.
  - Required: no response ever appears, `busy`=0 after the release, and a new command completes normally.
- **Checker**:
  - With `ALU_ISSUER_CHECK_EN` and a stub ALU flipping bit 0 of ADD 0x03+0x04: `rsp_result`=0x06 with `rsp_err`=1.
  - Without the macro: same result, `rsp_err`=0.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
// alu_issuer_pkg: shared widths, opcodes, response record and ALU reference function
package alu_issuer_pkg;
  localparam int DATA_W   = 8;
  localparam int OP_W     = 2;
  localparam int PIPE_LAT = 3;
  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_AND = 2'b01;
  localparam logic [OP_W-1:0] OP_OR  = 2'b10;
  localparam logic [OP_W-1:0] OP_XOR = 2'b11;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              err;
  } rsp_t;
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;
  function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                input logic [OP_W-1:0] op);
    return op == OP_ADD ? a + b : op == OP_AND ? a & b : op == OP_OR ? a | b : a ^ b;
  endfunction
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command and response valid/ready channels of the issuer
interface alu_cmd_issuer_if;
  import alu_issuer_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;
  modport master (output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err);
  modport slave  (input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err);
endinterface

// File: rtl/alu_cmd_issuer_rsp_fifo.sv
// alu_rsp_fifo: first-word-fall-through response FIFO with occupancy count
module alu_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         pop;
  assign count_o = wptr_q - rptr_q;
  assign empty_o = count_o == '0;
  assign pop     = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  // storage and wrap-bit pointers; a push into a full FIFO is only ever paired with a pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: drives the registered ALU, tracks its pipeline and returns results in order (checker macro ALU_ISSUER_CHECK_EN)
module alu_cmd_issuer
  import alu_issuer_pkg::*;
#(
  parameter int RSP_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_issuer_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
`ifdef ALU_ISSUER_CHECK_EN
  localparam int FW = $bits(rsp_t);
`else
  localparam int FW = DATA_W + 1;
`endif
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                acc, push, pop, empty;
  logic [CW-1:0]       fcnt;
  logic [FW-1:0]       din, dout;
  // credit covers in-flight commands plus stored responses, so the FIFO can never overflow
  assign bus.cmd_ready = $countones(vld_q) + int'(fcnt) < RSP_DEPTH;
  assign bus.rsp_valid = ~empty;
  assign acc           = bus.cmd_valid & bus.cmd_ready;
  assign push          = vld_q[PIPE_LAT-1];
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign busy          = busy_q;
  // next operands, valid shift and busy computed from next-state so busy is a clean register
  always_comb begin
    a_d    = acc ? bus.cmd_a : a_q;
    b_d    = acc ? bus.cmd_b : b_q;
    op_d   = acc ? bus.cmd_op : op_q;
    vld_d  = {vld_q[PIPE_LAT-2:0], acc};
    busy_d = (|vld_d) || (int'(fcnt) + int'(push) - int'(pop) != 0);
  end
  // ALU operand registers and pipeline tracking state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      vld_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
    end
`ifdef ALU_ISSUER_CHECK_EN
  cmd_t              cpy_q [PIPE_LAT];
  logic [DATA_W-1:0] exp_res;
  rsp_t              rsp_in, rsp_out;
  assign exp_res        = alu_ref(cpy_q[PIPE_LAT-1].a, cpy_q[PIPE_LAT-1].b, cpy_q[PIPE_LAT-1].op);
  assign rsp_in         = '{result: alu_result, zero: alu_zero,
                            err: (alu_result != exp_res) || (alu_zero != (exp_res == '0))};
  assign din            = rsp_in;
  assign rsp_out        = dout;
  assign bus.rsp_result = rsp_out.result;
  assign bus.rsp_zero   = rsp_out.zero;
  assign bus.rsp_err    = rsp_out.err;
  // operand copies shift in lockstep with the valid bits so the last stage matches the captured result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) cpy_q[i] <= '0;
    end else begin
      cpy_q[0] <= {a_d, b_d, op_d};
      for (int i = 1; i < PIPE_LAT; i++) cpy_q[i] <= cpy_q[i-1];
    end
`else
  assign din                           = {alu_result, alu_zero};
  assign {bus.rsp_result, bus.rsp_zero} = dout;
  assign bus.rsp_err                   = 1'b0;
`endif
  alu_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(FW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (dout),
    .empty_o (empty),
    .count_o (fcnt)
  );
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed self-checking bench with a two-stage registered ALU stub
module tb_alu_cmd_issuer;
  import alu_issuer_pkg::*;
`ifdef ALU_ISSUER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_op;
  logic       alu_zero, busy;
  logic [7:0] ra, rb;
  logic [1:0] rop;
  logic       flip;
  int         total = 0;
  int         bad = 0;
  int         outstanding;
  int         max_out = 0;
  alu_cmd_issuer_if bus();
  alu_cmd_issuer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  // ALU stub: input register, then output register; optional bit-0 fault on ADD 3+4
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= 0; rb <= 0; rop <= 0; alu_result <= 0; alu_zero <= 0;
    end else begin
      ra         <= alu_a;
      rb         <= alu_b;
      rop        <= alu_op;
      alu_result <= alu_ref(ra, rb, rop) ^ {7'd0, flip && rop == OP_ADD && ra == 8'd3 && rb == 8'd4};
      alu_zero   <= alu_ref(ra, rb, rop) == 8'd0;
    end
  // accepted-but-not-yet-popped commands, sampled before the edge updates
  always @(posedge clk or negedge rst_n)
    if (!rst_n) outstanding <= 0;
    else outstanding <= outstanding + int'(bus.cmd_valid & bus.cmd_ready) - int'(bus.rsp_valid & bus.rsp_ready);
  always @(negedge clk) if (outstanding > max_out) max_out = outstanding;

  task automatic test_reset();
    rst_n = 1'b0; flip = 1'b0;
    bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_op = 0; bus.rsp_ready = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({alu_a, alu_b, alu_op} !== 18'd0) begin bad++; $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_op}); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== 10'd0) begin bad++; $display("FAIL reset_rsp got %h want 0", {bus.rsp_result, bus.rsp_zero, bus.rsp_err}); end
  endtask

  task automatic test_single_add();
    bus.cmd_valid = 1; bus.cmd_a = 8'hF0; bus.cmd_b = 8'h20; bus.cmd_op = OP_ADD;
    @(negedge clk);
    bus.cmd_valid = 0;
    total++; if ({alu_a, alu_b, alu_op} !== {8'hF0, 8'h20, 2'b00}) begin bad++; $display("FAIL add_alu_regs got %h want f02000", {alu_a, alu_b, alu_op}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy got %b want 1", busy); end
    repeat (2) @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL add_early got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL add_valid got %b want 1", bus.rsp_valid); end
    total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {8'h10, 1'b0, 1'b0})
      begin bad++; $display("FAIL add_rsp got %h/%b/%b want 10/0/0", bus.rsp_result, bus.rsp_zero, bus.rsp_err); end
    @(negedge clk);
    total++; if ({bus.rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL add_drain got %b want 00", {bus.rsp_valid, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] cmds [4] = '{{8'h01, 8'hFF, 2'b00}, {8'h0F, 8'hF0, 2'b01}, {8'hA0, 8'h05, 2'b10}, {8'h5A, 8'h5A, 2'b11}};
    logic [8:0]  exps [4] = '{{8'h00, 1'b1}, {8'h00, 1'b1}, {8'hA5, 1'b0}, {8'h00, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1; {bus.cmd_a, bus.cmd_b, bus.cmd_op} = cmds[i];
      @(negedge clk);
    end
    bus.cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {1'b1, exps[i], 1'b0})
        begin bad++; $display("FAIL b2b_rsp%0d got v=%b %h/%b/%b want v=1 %h/%b/0", i, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err, exps[i][8:1], exps[i][0]); end
    end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_backpressure();
    int   idx = 0, got = 0, late_rdy = 0;
    logic rdy;
    bus.rsp_ready = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1; bus.cmd_a = 8'(idx * 17); bus.cmd_b = 8'(idx + 1); bus.cmd_op = OP_ADD;
      rdy = bus.cmd_ready;
      if (idx >= 8 && rdy) late_rdy++;
      @(posedge clk);
      if (rdy) idx++;
    end
    total++; if (idx !== 8) begin bad++; $display("FAIL bp_accepted got %0d want 8", idx); end
    total++; if (late_rdy !== 0) begin bad++; $display("FAIL bp_ready_held got %0d cycles want 0", late_rdy); end
    @(negedge clk);
    bus.rsp_ready = 1;
    for (int c = 0; c < 100 && got < 12; c++) begin
      if (c > 0) @(negedge clk);
      bus.cmd_valid = idx < 12; bus.cmd_a = 8'(idx * 17); bus.cmd_b = 8'(idx + 1);
      rdy = bus.cmd_ready;
      if (bus.rsp_valid) begin
        total++; if (bus.rsp_result !== 8'(18 * got + 1) || bus.rsp_err !== 1'b0)
          begin bad++; $display("FAIL bp_rsp%0d got %h err=%b want %h err=0", got, bus.rsp_result, bus.rsp_err, 8'(18 * got + 1)); end
        got++;
      end
      @(posedge clk);
      if (rdy && idx < 12) idx++;
    end
    @(negedge clk);
    bus.cmd_valid = 0;
    total++; if (idx !== 12 || got !== 12) begin bad++; $display("FAIL bp_complete got acc=%0d rsp=%0d want 12/12", idx, got); end
    repeat (4) @(negedge clk);
    total++; if ({bus.rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL bp_no_dup got %b want 00", {bus.rsp_valid, busy}); end
  endtask

  task automatic test_reset_midflight();
    int seen = 0, n = 0;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1; bus.cmd_a = 8'(i + 1); bus.cmd_b = 8'h10; bus.cmd_op = OP_OR;
      @(negedge clk);
    end
    rst_n = 0; bus.cmd_a = 8'h77;
    @(negedge clk);
    rst_n = 1; bus.cmd_valid = 0;
    total++; if ({busy, bus.cmd_ready, alu_a} !== {1'b0, 1'b1, 8'h00}) begin bad++; $display("FAIL mid_reset_state got %b%b %h want 1'b0 1'b1 00", busy, bus.cmd_ready, alu_a); end
    repeat (8) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_ghost_rsp got %0d want 0", seen); end
    bus.cmd_valid = 1; bus.cmd_a = 8'h33; bus.cmd_b = 8'h0F; bus.cmd_op = OP_XOR;
    @(negedge clk);
    bus.cmd_valid = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    total++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {1'b1, 8'h3C, 1'b0, 1'b0})
      begin bad++; $display("FAIL mid_new_cmd got v=%b %h/%b/%b want v=1 3c/0/0", bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_checker();
    int n = 0;
    flip = 1;
    bus.cmd_valid = 1; bus.cmd_a = 8'h03; bus.cmd_b = 8'h04; bus.cmd_op = OP_ADD;
    @(negedge clk);
    bus.cmd_valid = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    total++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {1'b1, 8'h06, 1'b0, EXP_ERR})
      begin bad++; $display("FAIL checker got v=%b %h/%b/%b want v=1 06/0/%b", bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err, EXP_ERR); end
    @(negedge clk);
    flip = 0;
  endtask

  task automatic test_credit_bound();
    total++; if (max_out !== 8) begin bad++; $display("FAIL credit_bound got max outstanding %0d want 8", max_out); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_checker();
    test_credit_bound();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
